// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//
// Direct-mapped, write-through, no-write-allocate data cache sitting between the
// pipeline memory stage and the backing data memory. One 32-bit word per line.
//
// Optional feature macro: DCACHE_STATS_EN
//   When defined, adds hit_count / miss_count outputs that count IDLE-state
//   load hits and load misses (stores are not counted, both wrap at 2^32).
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   req_valid  : load/store present in the M stage
//   we         : 1 = store, 0 = load
//   addr       : byte address
//   wdata      : store data, right-aligned
//   size       : funct3 code (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
//   rdata      : extended load result (0 when no load completes)
//   stall      : request cannot complete this cycle
//   mem_req    : backing-memory request valid
//   mem_we     : backing-memory write
//   mem_addr   : word-aligned backing-memory address
//   mem_wdata  : lane-aligned store data
//   mem_be     : byte enables
//   mem_ready  : backing memory completes the request this cycle
//   mem_rdata  : full word from backing memory, valid with mem_ready on a read
//   hit_count  : (DCACHE_STATS_EN) load hit counter
//   miss_count : (DCACHE_STATS_EN) load miss counter
// -----------------------------------------------------------------------------
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [2:0]            size,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int LINES     = 1 << INDEX_BITS;
    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int LINE_BITS = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Line storage. Valid bits live in flops so reset can clear them all at once;
    // tag and data arrays need a combinational read for zero-latency hits.
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] r_data_mem [LINES];

    // Request copy captured when leaving IDLE; drives the memory side and the
    // refill extraction so the pipeline inputs are not needed mid-handshake.
    logic [LINE_BITS-1:0]  r_line_addr;
    logic [1:0]            r_off;
    logic [2:0]            r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_be;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic [INDEX_BITS-1:0] w_lat_index;
    logic [TAG_BITS-1:0]   w_lat_tag;
    logic                  w_lat_hit;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_lane_wdata;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_latch;
    logic                  w_fill;
    logic                  w_merge;
    logic                  w_hit_inc;
    logic                  w_miss_inc;

    assign w_index     = addr[INDEX_BITS+1:2];
    assign w_tag       = addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_hit       = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
    assign w_lat_index = r_line_addr[INDEX_BITS-1:0];
    assign w_lat_tag   = r_line_addr[LINE_BITS-1:INDEX_BITS];
    assign w_lat_hit   = r_valid[w_lat_index] && (r_tag_mem[w_lat_index] == w_lat_tag);

    assign mem_addr  = {r_line_addr, 2'b00};
    assign mem_wdata = r_wdata;

    // Byte/half selection by offset, then sign or zero extension by funct3.
    function automatic logic [DATA_WIDTH-1:0] f_extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [2:0]            sz
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            3'b000:  f_extract = {{24{b[7]}}, b};
            3'b001:  f_extract = {{16{h[15]}}, h};
            3'b100:  f_extract = {24'd0, b};
            3'b101:  f_extract = {16'd0, h};
            default: f_extract = word;
        endcase
    endfunction

    // Store lane placement: narrow stores replicate across all lanes so the
    // byte enables alone select what memory keeps.
    always_comb begin
        w_be         = 4'b1111;
        w_lane_wdata = wdata;
        case (size)
            3'b000: begin
                w_be         = 4'b0001 << addr[1:0];
                w_lane_wdata = {4{wdata[7:0]}};
            end
            3'b001: begin
                w_be         = addr[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be         = 4'b1111;
                w_lane_wdata = wdata;
            end
        endcase
    end

    // Write-through merge of enabled bytes into the cached word on a store hit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign w_merged[gi*8 +: 8] = r_be[gi] ? r_wdata[gi*8 +: 8]
                                                  : r_data_mem[w_lat_index][gi*8 +: 8];
        end
    endgenerate

    // FSM next state and outputs
    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'b0000;
        rdata        = '0;
        w_latch      = 1'b0;
        w_fill       = 1'b0;
        w_merge      = 1'b0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (we) begin
                        stall        = 1'b1;
                        w_latch      = 1'b1;
                        w_state_next = S_WRITE;
                    end else if (w_hit) begin
                        rdata     = f_extract(r_data_mem[w_index], addr[1:0], size);
                        w_hit_inc = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        w_latch      = 1'b1;
                        w_miss_inc   = 1'b1;
                        w_state_next = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    w_fill       = 1'b1;
                    rdata        = f_extract(mem_rdata, r_off, r_size);
                    w_state_next = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            S_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                mem_be  = r_be;
                if (mem_ready) begin
                    w_merge      = w_lat_hit;
                    w_state_next = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, valid bits and request copy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_line_addr <= '0;
            r_off       <= '0;
            r_size      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fill) begin
                r_valid[w_lat_index] <= 1'b1;
            end
            if (w_latch) begin
                r_line_addr <= addr[ADDR_WIDTH-1:2];
                r_off       <= addr[1:0];
                r_size      <= size;
                r_wdata     <= w_lane_wdata;
                r_be        <= w_be;
            end
        end
    end

    // Tag/data arrays. No reset: contents are qualified by r_valid, and writes
    // only happen out of REFILL/WRITE, which reset forces back to IDLE.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag_mem[w_lat_index]  <= w_lat_tag;
            r_data_mem[w_lat_index] <= mem_rdata;
        end else if (w_merge) begin
            r_data_mem[w_lat_index] <= w_merged;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_inc) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_inc) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    // Counter strobes have no consumer without the statistics feature.
    logic w_unused_stats;
    assign w_unused_stats = w_hit_inc ^ w_miss_inc;
`endif

endmodule
